// File: rtl/score_bank.sv
// score_bank: per-player current/best score store driven by a WIN/TIMEOUT/CLR event FSM.
// Optional leader tracking is built when SCORE_BANK_LEADER_EN is defined.
module score_bank #(
  parameter int NUM_PLAYERS = 4,
  parameter int PID_W       = 2,
  parameter int SCORE_W     = 4,
  parameter int LVL_W       = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic [1:0]         ev_op,
  input  logic [PID_W-1:0]   ev_pid,
  input  logic [LVL_W-1:0]   lvl_inp,
  input  logic               clr_all,
  output logic               done,
  output logic               err,
  output logic [SCORE_W-1:0] disp_score,
  output logic [SCORE_W-1:0] disp_score_max,
  output logic [PID_W-1:0]   leader_pid,
  output logic [SCORE_W-1:0] leader_score
);

  localparam int DEPTH = 2 * NUM_PLAYERS;
  localparam int AW    = PID_W + 1;

  localparam logic [1:0] OP_WIN = 2'b00;
  localparam logic [1:0] OP_TO  = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RC,
    S_RB,
    S_WC,
    S_WB,
    S_CLR
  } state_t;

  state_t r_state;

  logic [1:0]         r_op;
  logic [PID_W-1:0]   r_pid;
  logic [LVL_W-1:0]   r_lvl;
  logic               r_bad;
  logic [SCORE_W-1:0] r_cur;
  logic [SCORE_W-1:0] r_best;
  logic [SCORE_W-1:0] r_new;
  logic [SCORE_W-1:0] r_rdata;
  logic [AW-1:0]      r_clr_addr;
  logic               r_done;
  logic               r_err;
  logic [SCORE_W-1:0] r_disp;
  logic [SCORE_W-1:0] r_disp_max;

  logic [SCORE_W-1:0] r_mem [DEPTH];

  logic               w_bad;
  logic               w_rsv;
  logic               w_best_wr;
  logic               w_clr_last;
  logic               w_re;
  logic               w_we;
  logic [AW-1:0]      w_raddr;
  logic [AW-1:0]      w_waddr;
  logic [SCORE_W-1:0] w_wdata;
  logic [SCORE_W-1:0] w_new;
  logic [SCORE_W:0]   w_sum;

  assign ev_ready   = (r_state == S_IDLE) & ~clr_all;
  assign w_bad      = ({1'b0, ev_pid} >= AW'(NUM_PLAYERS));
  assign w_rsv      = (r_op == OP_RSV);
  assign w_best_wr  = ~w_rsv & (r_new > r_best);
  assign w_clr_last = (r_clr_addr == AW'(DEPTH - 1));

  assign done           = r_done;
  assign err            = r_err;
  assign disp_score     = r_disp;
  assign disp_score_max = r_disp_max;

  // Next current score from the latched current score and op.
  always_comb begin
    w_sum = {1'b0, r_cur}
          + (SCORE_W + 1)'(r_lvl)
          + (SCORE_W + 1)'(1);
    w_new = r_cur;
    unique case (1'b1)
      (r_op == OP_WIN): begin
        w_new = w_sum[SCORE_W] ? '1
                               : w_sum[SCORE_W-1:0];
      end
      (r_op == OP_TO): begin
        w_new = (r_cur == '0) ? '0
                              : r_cur - 1'b1;
      end
      (r_op == OP_CLR): w_new = '0;
      default:          w_new = r_cur;
    endcase
  end

  // Single-port access schedule: two reads, then up to two writes.
  always_comb begin
    w_re    = 1'b0;
    w_raddr = {r_pid, 1'b0};
    w_we    = 1'b0;
    w_waddr = {r_pid, 1'b0};
    w_wdata = '0;
    unique case (r_state)
      S_RC: w_re = ~r_bad;
      S_RB: begin
        w_re    = 1'b1;
        w_raddr = {r_pid, 1'b1};
      end
      S_WC: begin
        w_we    = ~w_rsv;
        w_wdata = w_new;
      end
      S_WB: begin
        w_we    = w_best_wr;
        w_waddr = {r_pid, 1'b1};
        w_wdata = r_new;
      end
      S_CLR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_addr;
      end
      default: ;
    endcase
  end

  // Score RAM with registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (w_we) begin
        r_mem[w_waddr] <= w_wdata;
      end
      if (w_re) begin
        r_rdata <= r_mem[w_raddr];
      end
    end
  end

  // Event sequencer with registered done/err/display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_WIN;
      r_pid      <= '0;
      r_lvl      <= '0;
      r_bad      <= 1'b0;
      r_cur      <= '0;
      r_best     <= '0;
      r_new      <= '0;
      r_clr_addr <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_disp     <= '0;
      r_disp_max <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (clr_all) begin
            r_clr_addr <= '0;
            r_state    <= S_CLR;
          end else if (ev_valid) begin
            r_op    <= ev_op;
            r_pid   <= ev_pid;
            r_lvl   <= lvl_inp;
            r_bad   <= w_bad;
            r_err   <= w_bad;
            r_state <= S_RC;
          end
        end
        S_RC: begin
          r_state <= r_bad ? S_IDLE : S_RB;
        end
        S_RB: begin
          r_cur   <= r_rdata;
          r_state <= S_WC;
        end
        S_WC: begin
          r_best  <= r_rdata;
          r_new   <= w_new;
          r_done  <= 1'b1;
          r_state <= S_WB;
        end
        S_WB: begin
          if (!w_rsv) begin
            r_disp     <= r_new;
            r_disp_max <= w_best_wr ? r_new : r_best;
          end
          r_state <= S_IDLE;
        end
        S_CLR: begin
          if (w_clr_last) begin
            r_disp     <= '0;
            r_disp_max <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SCORE_BANK_LEADER_EN
  logic [PID_W-1:0]   r_lead_pid;
  logic [SCORE_W-1:0] r_lead_score;

  // Highest best score seen; ties keep the earlier holder.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lead_pid   <= '0;
      r_lead_score <= '0;
    end else if ((r_state == S_CLR) && w_clr_last) begin
      r_lead_pid   <= '0;
      r_lead_score <= '0;
    end else if ((r_state == S_WB) && w_best_wr
                 && (r_new > r_lead_score)) begin
      r_lead_pid   <= r_pid;
      r_lead_score <= r_new;
    end
  end

  assign leader_pid   = r_lead_pid;
  assign leader_score = r_lead_score;
`else
  assign leader_pid   = '0;
  assign leader_score = '0;
`endif

endmodule

// File: tb/tb_score_bank.sv
// tb_score_bank: directed self-checking bench for score_bank.
// Runs with NUM_PLAYERS=4, PID_W=3 so out-of-range pids can be driven.
module tb_score_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_ready;
  logic [1:0] ev_op = 2'b00;
  logic [2:0] ev_pid = 3'd0;
  logic [1:0] lvl_inp = 2'd0;
  logic       clr_all = 1'b0;
  logic       done;
  logic       err;
  logic [3:0] disp_score;
  logic [3:0] disp_score_max;
  logic [2:0] leader_pid;
  logic [3:0] leader_score;

  int n_cmp = 0;
  int n_bad = 0;

  score_bank #(
    .NUM_PLAYERS(4),
    .PID_W(3),
    .SCORE_W(4),
    .LVL_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_op(ev_op),
    .ev_pid(ev_pid),
    .lvl_inp(lvl_inp),
    .clr_all(clr_all),
    .done(done),
    .err(err),
    .disp_score(disp_score),
    .disp_score_max(disp_score_max),
    .leader_pid(leader_pid),
    .leader_score(leader_score)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, want finish");
    $fatal(1, "watchdog");
  end

  // Issue one event from a negedge; report done/err positions and ready per cycle.
  task automatic do_event(input logic [1:0] op, input logic [2:0] pid,
                          input logic [1:0] lvl, output int lat,
                          output int err_at, output logic [6:1] rdy);
    int w;
    lat = 0;
    err_at = 0;
    rdy = '0;
    ev_op = op;
    ev_pid = pid;
    lvl_inp = lvl;
    ev_valid = 1'b1;
    w = 0;
    while (!ev_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 ev_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      rdy[n] = ev_ready;
      if (done && lat == 0) lat = n;
      if (err && err_at == 0) err_at = n;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp += 4;
    if (done !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_pulse: done=%b err=%b want 0 0", done, err);
    end
    if (disp_score !== 4'd0 || disp_score_max !== 4'd0) begin
      n_bad++;
      $display("FAIL rst_disp: got %0d/%0d want 0/0",
               disp_score, disp_score_max);
    end
    if (leader_pid !== 3'd0 || leader_score !== 4'd0) begin
      n_bad++;
      $display("FAIL rst_leader: got %0d/%0d want 0/0",
               leader_pid, leader_score);
    end
    if (ev_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready: got %b want 1", ev_ready);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_win;
    int lat, ea;
    logic [6:1] rdy;
    do_event(2'b00, 3'd1, 2'd2, lat, ea, rdy);
    n_cmp += 5;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL win1_latency: got %0d want 4", lat);
    end
    if (rdy[4:1] !== 4'b0000 || rdy[5] !== 1'b1) begin
      n_bad++;
      $display("FAIL win1_ready: got %b want 11_0000", rdy);
    end
    if (ea !== 0) begin
      n_bad++;
      $display("FAIL win1_err: err at %0d want none", ea);
    end
    if (disp_score !== 4'd3) begin
      n_bad++;
      $display("FAIL win1_disp: got %0d want 3", disp_score);
    end
    if (disp_score_max !== 4'd3) begin
      n_bad++;
      $display("FAIL win1_max: got %0d want 3", disp_score_max);
    end
  endtask

  task automatic test_saturation;
    int lat, ea;
    logic [6:1] rdy;
    logic [3:0] exp_s [6];
    exp_s = '{4'd4, 4'd8, 4'd12, 4'd15, 4'd15, 4'd15};
    for (int k = 0; k < 6; k++) begin
      do_event(2'b00, 3'd0, 2'd3, lat, ea, rdy);
      n_cmp++;
      if (disp_score !== exp_s[k] || disp_score_max !== exp_s[k]) begin
        n_bad++;
        $display("FAIL sat_win%0d: got %0d/%0d want %0d/%0d", k,
                 disp_score, disp_score_max, exp_s[k], exp_s[k]);
      end
    end
    do_event(2'b01, 3'd0, 2'd0, lat, ea, rdy);
    n_cmp++;
    if (disp_score !== 4'd14 || disp_score_max !== 4'd15) begin
      n_bad++;
      $display("FAIL sat_timeout: got %0d/%0d want 14/15",
               disp_score, disp_score_max);
    end
    do_event(2'b10, 3'd0, 2'd0, lat, ea, rdy);
    n_cmp++;
    if (disp_score !== 4'd0 || disp_score_max !== 4'd15) begin
      n_bad++;
      $display("FAIL sat_clrp: got %0d/%0d want 0/15",
               disp_score, disp_score_max);
    end
    do_event(2'b00, 3'd0, 2'd0, lat, ea, rdy);
    n_cmp++;
    if (disp_score !== 4'd1 || disp_score_max !== 4'd15) begin
      n_bad++;
      $display("FAIL sat_after_clrp: got %0d/%0d want 1/15",
               disp_score, disp_score_max);
    end
  endtask

  task automatic test_timeout_zero;
    int lat, ea;
    logic [6:1] rdy;
    do_event(2'b01, 3'd2, 2'd0, lat, ea, rdy);
    n_cmp++;
    if (disp_score !== 4'd0 || disp_score_max !== 4'd0) begin
      n_bad++;
      $display("FAIL to_zero: got %0d/%0d want 0/0",
               disp_score, disp_score_max);
    end
  endtask

  task automatic test_bad_pid;
    int lat, ea;
    logic [6:1] rdy;
    do_event(2'b00, 3'd5, 2'd3, lat, ea, rdy);
    n_cmp += 4;
    if (ea !== 1) begin
      n_bad++;
      $display("FAIL bad_err: err at %0d want 1", ea);
    end
    if (lat !== 0) begin
      n_bad++;
      $display("FAIL bad_done: done at %0d want none", lat);
    end
    if (rdy[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_ready: got %b want 1 at cycle 2", rdy[2]);
    end
    if (disp_score !== 4'd0 || disp_score_max !== 4'd0) begin
      n_bad++;
      $display("FAIL bad_disp: got %0d/%0d want 0/0",
               disp_score, disp_score_max);
    end
    do_event(2'b01, 3'd1, 2'd0, lat, ea, rdy);
    n_cmp++;
    if (disp_score !== 4'd2 || disp_score_max !== 4'd3) begin
      n_bad++;
      $display("FAIL bad_after: got %0d/%0d want 2/3",
               disp_score, disp_score_max);
    end
  endtask

  task automatic test_reserved;
    int lat, ea;
    logic [6:1] rdy;
    do_event(2'b11, 3'd1, 2'd3, lat, ea, rdy);
    n_cmp += 2;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL rsv_done: got %0d want 4", lat);
    end
    if (disp_score !== 4'd2 || disp_score_max !== 4'd3) begin
      n_bad++;
      $display("FAIL rsv_disp: got %0d/%0d want 2/3",
               disp_score, disp_score_max);
    end
    do_event(2'b01, 3'd1, 2'd0, lat, ea, rdy);
    n_cmp++;
    if (disp_score !== 4'd1 || disp_score_max !== 4'd3) begin
      n_bad++;
      $display("FAIL rsv_nowrite: got %0d/%0d want 1/3",
               disp_score, disp_score_max);
    end
  endtask

  task automatic test_clr_all;
    int lat, ea, cnt;
    logic [6:1] rdy;
    logic [3:0] exp_s;
    ev_op = 2'b00;
    ev_pid = 3'd1;
    lvl_inp = 2'd2;
    ev_valid = 1'b1;
    clr_all = 1'b1;
    #1;
    n_cmp++;
    if (ev_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_prio: ready=%b want 0", ev_ready);
    end
    @(posedge clk);
    #1 clr_all = 1'b0;
    cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ev_ready) begin
        cnt = n;
        break;
      end
    end
    n_cmp += 2;
    if (cnt !== 9) begin
      n_bad++;
      $display("FAIL clr_len: ready after %0d want 9", cnt);
    end
    if (disp_score !== 4'd0 || disp_score_max !== 4'd0) begin
      n_bad++;
      $display("FAIL clr_disp: got %0d/%0d want 0/0",
               disp_score, disp_score_max);
    end
    do_event(2'b00, 3'd1, 2'd2, lat, ea, rdy);
    n_cmp++;
    if (disp_score !== 4'd3 || disp_score_max !== 4'd3) begin
      n_bad++;
      $display("FAIL clr_win: got %0d/%0d want 3/3",
               disp_score, disp_score_max);
    end
    for (int p = 0; p < 4; p++) begin
      if (p == 1) continue;
      do_event(2'b01, 3'(p), 2'd0, lat, ea, rdy);
      exp_s = 4'd0;
      n_cmp++;
      if (disp_score !== exp_s || disp_score_max !== exp_s) begin
        n_bad++;
        $display("FAIL clr_read_p%0d: got %0d/%0d want 0/0", p,
                 disp_score, disp_score_max);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat, ea;
    logic [6:1] rdy;
    do_event(2'b00, 3'd2, 2'd3, lat, ea, rdy);
    n_cmp++;
    if (disp_score !== 4'd4 || disp_score_max !== 4'd4) begin
      n_bad++;
      $display("FAIL rm_pre: got %0d/%0d want 4/4",
               disp_score, disp_score_max);
    end
    ev_op = 2'b00;
    ev_pid = 3'd1;
    lvl_inp = 2'd3;
    ev_valid = 1'b1;
    @(posedge clk);
    #1 ev_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp += 2;
    if (disp_score !== 4'd0 || disp_score_max !== 4'd0) begin
      n_bad++;
      $display("FAIL rm_disp: got %0d/%0d want 0/0",
               disp_score, disp_score_max);
    end
    if (done !== 1'b0 || ev_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_state: done=%b ready=%b want 0 1", done, ev_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_event(2'b00, 3'd1, 2'd0, lat, ea, rdy);
    n_cmp += 2;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL rm_lat: got %0d want 4", lat);
    end
    if (disp_score !== 4'd1 || disp_score_max !== 4'd1) begin
      n_bad++;
      $display("FAIL rm_win: got %0d/%0d want 1/1",
               disp_score, disp_score_max);
    end
    do_event(2'b01, 3'd2, 2'd0, lat, ea, rdy);
    n_cmp++;
    if (disp_score !== 4'd0 || disp_score_max !== 4'd0) begin
      n_bad++;
      $display("FAIL rm_p2: got %0d/%0d want 0/0",
               disp_score, disp_score_max);
    end
  endtask

  task automatic test_leader;
    int lat, ea;
    logic [6:1] rdy;
    logic [2:0] exp_p;
    logic [3:0] exp_s;
    do_event(2'b00, 3'd0, 2'd3, lat, ea, rdy);
    do_event(2'b00, 3'd0, 2'd2, lat, ea, rdy);
    do_event(2'b00, 3'd3, 2'd3, lat, ea, rdy);
    do_event(2'b00, 3'd3, 2'd2, lat, ea, rdy);
`ifdef SCORE_BANK_LEADER_EN
    exp_p = 3'd0;
    exp_s = 4'd7;
`else
    exp_p = 3'd0;
    exp_s = 4'd0;
`endif
    n_cmp += 2;
    if (disp_score !== 4'd7 || disp_score_max !== 4'd7) begin
      n_bad++;
      $display("FAIL ld_p3_7: got %0d/%0d want 7/7",
               disp_score, disp_score_max);
    end
    if (leader_pid !== exp_p || leader_score !== exp_s) begin
      n_bad++;
      $display("FAIL ld_tie: got %0d/%0d want %0d/%0d",
               leader_pid, leader_score, exp_p, exp_s);
    end
    do_event(2'b00, 3'd3, 2'd1, lat, ea, rdy);
`ifdef SCORE_BANK_LEADER_EN
    exp_p = 3'd3;
    exp_s = 4'd9;
`endif
    n_cmp += 2;
    if (disp_score !== 4'd9 || disp_score_max !== 4'd9) begin
      n_bad++;
      $display("FAIL ld_p3_9: got %0d/%0d want 9/9",
               disp_score, disp_score_max);
    end
    if (leader_pid !== exp_p || leader_score !== exp_s) begin
      n_bad++;
      $display("FAIL ld_new: got %0d/%0d want %0d/%0d",
               leader_pid, leader_score, exp_p, exp_s);
    end
    do_event(2'b10, 3'd3, 2'd0, lat, ea, rdy);
    n_cmp += 2;
    if (disp_score !== 4'd0 || disp_score_max !== 4'd9) begin
      n_bad++;
      $display("FAIL ld_clrp_disp: got %0d/%0d want 0/9",
               disp_score, disp_score_max);
    end
    if (leader_pid !== exp_p || leader_score !== exp_s) begin
      n_bad++;
      $display("FAIL ld_clrp: got %0d/%0d want %0d/%0d",
               leader_pid, leader_score, exp_p, exp_s);
    end
    clr_all = 1'b1;
    @(posedge clk);
    #1 clr_all = 1'b0;
    repeat (9) @(negedge clk);
    n_cmp++;
    if (leader_pid !== 3'd0 || leader_score !== 4'd0) begin
      n_bad++;
      $display("FAIL ld_clr: got %0d/%0d want 0/0",
               leader_pid, leader_score);
    end
  endtask

  initial begin
    test_reset();
    test_first_win();
    test_saturation();
    test_timeout_zero();
    test_bad_pid();
    test_reserved();
    test_clr_all();
    test_reset_mid();
    test_leader();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
